// File: rtl/vape_ctrl.sv
// VAPE execution-monitor controller: bound registers, arm/lock sequencing, violation aggregation.
// Optional cause capture in STATUS[15:8] is enabled by defining VAPE_CTRL_CAUSE_EN.
module vape_ctrl #(
    parameter int unsigned NVIOL     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0190
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      bus_addr,
    input  logic [15:0]      bus_wdata,
    input  logic             bus_wen,
    input  logic             bus_ren,
    output logic [15:0]      bus_rdata,
    input  logic [15:0]      pc,
    input  logic             exec,
    input  logic [NVIOL-1:0] viol_in,
    output logic [15:0]      ER_min,
    output logic [15:0]      ER_max,
    output logic [15:0]      OR_min,
    output logic [15:0]      OR_max,
    output logic             mon_reset,
    output logic             cfg_locked,
    output logic [2:0]       state_o
);

    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   er_min_q, er_max_q, or_min_q, or_max_q;
    logic [NVIOL-1:0] mask_q;
    logic            werr_q, werr_d, cerr_q, cerr_d;
    logic [DW-1:0]   rdata_q;
    logic [NVIOL-1:0] cause_w;

    // Address decode on exact word offsets; anything else is unmapped
    logic [DW-1:0] off;
    logic hit_er_min, hit_er_max, hit_or_min, hit_or_max, hit_ctrl, hit_mask;
    assign off        = bus_addr - BASE_ADDR;
    assign hit_er_min = (off == 16'd0);
    assign hit_er_max = (off == 16'd2);
    assign hit_or_min = (off == 16'd4);
    assign hit_or_max = (off == 16'd6);
    assign hit_ctrl   = (off == 16'd8);
    assign hit_mask   = (off == 16'd10);

    logic locked, cfg_wr, ctrl_wr, arm, disarm, clr, cfg_ok;
    logic [NVIOL-1:0] viol_m;
    logic v;
    assign locked  = (state_q != S_IDLE);
    assign cfg_wr  = bus_wen & (hit_er_min | hit_er_max | hit_or_min | hit_or_max | hit_mask);
    assign ctrl_wr = bus_wen & hit_ctrl;
    assign arm     = ctrl_wr & bus_wdata[0];
    assign disarm  = ctrl_wr & bus_wdata[1];
    assign clr     = ctrl_wr & bus_wdata[2];
    assign cfg_ok  = (er_min_q <= er_max_q) && (or_min_q <= or_max_q);
    assign viol_m  = viol_in & mask_q;
    assign v       = |viol_m;

    // Next-state and sticky flag logic
    always_comb begin
        state_d = state_q;
        werr_d  = werr_q;
        cerr_d  = cerr_q;
        if (cfg_wr && locked) werr_d = 1'b1;
        if (clr && !locked) begin
            werr_d = 1'b0;
            cerr_d = 1'b0;
        end
        if (state_q != S_IDLE && v) begin
            state_d = S_ABORT;
        end else begin
            unique case (state_q)
                S_IDLE: if (arm) begin
                    if (cfg_ok) state_d = S_ARMED;
                    else        cerr_d  = 1'b1;
                end
                S_ARMED: begin
                    if (exec)        state_d = S_RUN;
                    else if (disarm) state_d = S_IDLE;
                end
                S_RUN: begin
                    if (!exec)               state_d = S_ABORT;
                    else if (pc == er_max_q) state_d = S_DONE;
                    else if (disarm)         werr_d  = 1'b1;
                end
                S_DONE, S_ABORT: if (disarm) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef VAPE_CTRL_CAUSE_EN
    logic [NVIOL-1:0] cause_q, cause_d;

    // Latch on first entry to ABORT; exec-fall entry sees viol_m == 0
    always_comb begin
        cause_d = cause_q;
        if (state_d == S_ABORT && state_q != S_ABORT) cause_d = viol_m;
        if (state_d == S_IDLE && state_q != S_IDLE)   cause_d = '0;
        if (clr && !locked)                           cause_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cause_q <= '0;
        else       cause_q <= cause_d;
    end

    assign cause_w = cause_q;
`else
    assign cause_w = '0;
`endif

    logic [DW-1:0] status_c, rmux_c;
    always_comb begin
        status_c            = '0;
        status_c[2:0]       = 3'(state_q);
        status_c[3]         = werr_q;
        status_c[4]         = cerr_q;
        status_c[8 +: NVIOL] = cause_w;
    end

    always_comb begin
        rmux_c = '0;
        if (hit_er_min)      rmux_c = er_min_q;
        else if (hit_er_max) rmux_c = er_max_q;
        else if (hit_or_min) rmux_c = or_min_q;
        else if (hit_or_max) rmux_c = or_max_q;
        else if (hit_ctrl)   rmux_c = status_c;
        else if (hit_mask)   rmux_c[NVIOL-1:0] = mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            werr_q   <= 1'b0;
            cerr_q   <= 1'b0;
            er_min_q <= '0;
            er_max_q <= '0;
            or_min_q <= '0;
            or_max_q <= '0;
            mask_q   <= '1;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            werr_q  <= werr_d;
            cerr_q  <= cerr_d;
            rdata_q <= bus_ren ? rmux_c : '0;
            if (bus_wen && !locked) begin
                if (hit_er_min) er_min_q <= bus_wdata;
                if (hit_er_max) er_max_q <= bus_wdata;
                if (hit_or_min) or_min_q <= bus_wdata;
                if (hit_or_max) or_max_q <= bus_wdata;
                if (hit_mask)   mask_q   <= bus_wdata[NVIOL-1:0];
            end
        end
    end

    assign bus_rdata  = rdata_q;
    assign ER_min     = er_min_q;
    assign ER_max     = er_max_q;
    assign OR_min     = or_min_q;
    assign OR_max     = or_max_q;
    assign state_o    = 3'(state_q);
    assign cfg_locked = locked;
    // Combinational v term aborts the monitor in the violation cycle itself
    assign mon_reset  = (state_q == S_IDLE) | (state_q == S_ABORT) | v;

endmodule

// File: tb/tb_vape_ctrl.sv
// Directed self-checking bench for vape_ctrl (default NVIOL=4, BASE_ADDR=0x0190).
module tb_vape_ctrl;

    localparam logic [15:0] BASE = 16'h0190;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_addr, bus_wdata, bus_rdata, pc;
    logic        bus_wen, bus_ren, exec;
    logic [3:0]  viol_in;
    logic [15:0] ER_min, ER_max, OR_min, OR_max;
    logic        mon_reset, cfg_locked;
    logic [2:0]  state_o;
    logic [15:0] rd;

    int tests = 0;
    int fails = 0;

`ifdef VAPE_CTRL_CAUSE_EN
    localparam logic [15:0] ST_VIOL = 16'h0404;
`else
    localparam logic [15:0] ST_VIOL = 16'h0004;
`endif

    vape_ctrl #(.NVIOL(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
        .bus_ren(bus_ren), .bus_rdata(bus_rdata),
        .pc(pc), .exec(exec), .viol_in(viol_in),
        .ER_min(ER_min), .ER_max(ER_max), .OR_min(OR_min), .OR_max(OR_max),
        .mon_reset(mon_reset), .cfg_locked(cfg_locked), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] off, input logic [15:0] data);
        bus_addr  = BASE + off;
        bus_wdata = data;
        bus_wen   = 1'b1;
        tick();
        bus_wen   = 1'b0;
    endtask

    task automatic rd_reg(input logic [15:0] off, output logic [15:0] data);
        bus_addr = BASE + off;
        bus_ren  = 1'b1;
        tick();
        bus_ren  = 1'b0;
        data     = bus_rdata;
    endtask

    initial begin
        reset = 1'b1; bus_addr = '0; bus_wdata = '0; bus_wen = 1'b0; bus_ren = 1'b0;
        pc = '0; exec = 1'b0; viol_in = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_state", 16'(state_o), 16'h0);
        check("rst_monreset", 16'(mon_reset), 16'h1);
        check("rst_locked", 16'(cfg_locked), 16'h0);
        check("rst_rdata", bus_rdata, 16'h0);
        rd_reg(16'd8, rd);  check("rst_status", rd, 16'h0000);
        tick();             check("rdata_idle_zero", bus_rdata, 16'h0000);
        rd_reg(16'd10, rd); check("rst_mask", rd, 16'h000F);
        rd_reg(16'd12, rd); check("unmapped_read", rd, 16'h0000);

        // Normal run to DONE
        wr(16'd0, 16'hE000); wr(16'd2, 16'hE0FE); wr(16'd4, 16'h0400); wr(16'd6, 16'h04FF);
        check("er_max_out", ER_max, 16'hE0FE);
        check("or_min_out", OR_min, 16'h0400);
        rd_reg(16'd6, rd);  check("or_max_read", rd, 16'h04FF);
        wr(16'd8, 16'h0001);
        check("arm_state", 16'(state_o), 16'h1);
        check("arm_monreset", 16'(mon_reset), 16'h0);
        check("arm_locked", 16'(cfg_locked), 16'h1);
        exec = 1'b1; pc = 16'h0000; tick();
        check("run_state", 16'(state_o), 16'h2);
        pc = 16'hE0FE; tick();
        check("done_state", 16'(state_o), 16'h3);
        exec = 1'b0; pc = 16'h0000;
        wr(16'd8, 16'h0002);
        check("disarm_done", 16'(state_o), 16'h0);

        // Invalid config arm
        wr(16'd0, 16'hE100); wr(16'd2, 16'hE000);
        wr(16'd8, 16'h0001);
        check("cerr_state", 16'(state_o), 16'h0);
        rd_reg(16'd8, rd);  check("cerr_status", rd, 16'h0010);
        wr(16'd8, 16'h0004);
        rd_reg(16'd8, rd);  check("clr_status", rd, 16'h0000);

        // Locked write rejected
        wr(16'd0, 16'hE000); wr(16'd2, 16'hE0FE);
        wr(16'd8, 16'h0001);
        wr(16'd0, 16'h1234);
        check("locked_ermin", ER_min, 16'hE000);
        rd_reg(16'd8, rd);  check("werr_status", rd, 16'h0009);
        wr(16'd8, 16'h0002);
        wr(16'd8, 16'h0004);
        rd_reg(16'd8, rd);  check("werr_clr", rd, 16'h0000);

        // Violation abort with cause
        wr(16'd8, 16'h0001);
        exec = 1'b1; tick();
        check("run2_state", 16'(state_o), 16'h2);
        viol_in = 4'b0100; #1;
        check("viol_monreset_same_cycle", 16'(mon_reset), 16'h1);
        tick();
        viol_in = 4'b0000; #1;
        check("abort_state", 16'(state_o), 16'h4);
        check("abort_monreset", 16'(mon_reset), 16'h1);
        rd_reg(16'd8, rd);  check("abort_status", rd, ST_VIOL);
        viol_in = 4'b0001; tick(); viol_in = 4'b0000;
        rd_reg(16'd8, rd);  check("cause_sticky", rd, ST_VIOL);
        viol_in = 4'b0010;
        wr(16'd8, 16'h0002);
        viol_in = 4'b0000;
        check("disarm_viol_abort", 16'(state_o), 16'h4);
        wr(16'd8, 16'h0002);
        check("disarm_abort", 16'(state_o), 16'h0);
        exec = 1'b0;
        rd_reg(16'd8, rd);  check("cause_cleared", rd, 16'h0000);

        // Masked violations ignored; reset mid-run
        wr(16'd10, 16'h0000);
        wr(16'd8, 16'h0001);
        exec = 1'b1; viol_in = 4'hF; tick();
        check("masked_run", 16'(state_o), 16'h2);
        check("masked_monreset", 16'(mon_reset), 16'h0);
        tick();
        check("masked_stay_run", 16'(state_o), 16'h2);
        reset = 1'b1; tick(); reset = 1'b0;
        viol_in = 4'h0; exec = 1'b0;
        check("midrun_reset_state", 16'(state_o), 16'h0);
        check("midrun_reset_ermin", ER_min, 16'h0000);
        check("midrun_reset_monreset", 16'(mon_reset), 16'h1);
        rd_reg(16'd10, rd); check("midrun_reset_mask", rd, 16'h000F);

        // Exec falling aborts with zero cause (bounds all 0, valid)
        wr(16'd8, 16'h0001);
        exec = 1'b1; pc = 16'h0005; tick();
        exec = 1'b0; tick();
        check("execfall_abort", 16'(state_o), 16'h4);
        rd_reg(16'd8, rd);  check("execfall_status", rd, 16'h0004);
        wr(16'd8, 16'h0002);

        // Violation wins over pc==ER_MAX
        wr(16'd8, 16'h0001);
        exec = 1'b1; tick();
        check("run3_state", 16'(state_o), 16'h2);
        pc = 16'h0000; viol_in = 4'b0001; tick();
        viol_in = 4'b0000; exec = 1'b0;
        check("viol_vs_done", 16'(state_o), 16'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vape_ctrl.md
# vape_ctrl

Configuration and sequencing controller for the VAPE execution monitor. It holds the ER/OR bound registers behind a small peripheral bus and locks them once armed. It aggregates violation sources into the monitor's abort input and tracks each attestation run through IDLE/ARMED/RUN/DONE/ABORT with a readable status word. It sits between the CPU peripheral bus and the monitor.

## Interface
- NVIOL, 4, number of violation sources (1..8)
- BASE_ADDR, 16'h0190, byte base of the register window (word-aligned)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bus_addr  in  16  byte address
- bus_wdata  in  16  write data
- bus_wen  in  1  single-cycle write strobe
- bus_ren  in  1  read strobe
- bus_rdata  out  16  read data, registered
- pc  in  16  current program counter
- exec  in  1  monitor exec flag
- viol_in  in  NVIOL  violation pulses/levels from checkers
- ER_min, ER_max, OR_min, OR_max  out  16 each  bounds to monitor
- mon_reset  out  1  abort/hold input to monitor
- cfg_locked  out  1  bounds write-protected
- state_o  out  3  current state

## Operation
- Register map (offset from BASE_ADDR): 0 ER_MIN, 2 ER_MAX, 4 OR_MIN, 6 OR_MAX (RW), 8 CTRL/STATUS, 10 MASK (RW, low NVIOL bits).
- CTRL write:
  - bit0 ARM.
  - bit1 DISARM.
  - bit2 CLR (clears sticky flags, IDLE only).
- STATUS read:
  - [2:0] state.
  - bit3 WERR (rejected write).
  - bit4 CERR (arm with invalid config).
  - [8+NVIOL-1:8] cause.
  - Other bits 0.
- State encoding: IDLE=0, ARMED=1, RUN=2, DONE=3, ABORT=4.
- Masked violation: v = |(viol_in & MASK).
- Transitions, checked in this priority order:
  - Any state except IDLE, with v=1 → ABORT.
  - IDLE, ARM:
    - If ER_MIN<=ER_MAX and OR_MIN<=OR_MAX (unsigned) → ARMED.
    - Otherwise stay in IDLE and set CERR.
  - ARMED, exec=1 → RUN.
  - ARMED, DISARM → IDLE.
  - RUN, exec=0 → ABORT.
  - RUN, pc==ER_MAX → DONE.
  - RUN, DISARM → ignored; set WERR.
  - DONE or ABORT, DISARM → IDLE.
- cfg_locked = (state != IDLE).
  - Writes to offsets 0..6 or 10 while locked are dropped and set WERR.
- mon_reset = (state==IDLE) | (state==ABORT) | v. The v term is combinational, so the monitor is aborted in the same cycle as the violation.
- Cause capture:
  - On the first transition into ABORT, cause latches viol_in & MASK.
  - If ABORT was caused by exec falling, cause stays 0.
  - Later violations do not change cause until DISARM.
- Unmapped addresses: writes ignored; reads return 0.

## Timing
- All state changes are registered on the clk rising edge.
- Bus write effect is visible one cycle after the bus_wen cycle.
- bus_rdata is valid the cycle after bus_ren and is 0 in every other cycle.
- Reset values:
  - state IDLE.
  - All bounds 0.
  - MASK all ones.
  - Flags and cause 0.
  - bus_rdata 0.
  - cfg_locked 0.
  - mon_reset 1.
- Reset mid-run: the next cycle is IDLE with all registers cleared. The mon_reset=1 that results holds the monitor in abort.
- ARMED→RUN occurs the cycle after exec is first sampled 1.
- A violation and pc==ER_MAX in the same cycle → ABORT.
- DISARM and a violation in the same cycle → ABORT.
- A read and a write to the same address in the same cycle return the old value.

## Configuration
- VAPE_CTRL_CAUSE_EN:
  - Defined: cause register and STATUS[15:8] implemented as above.
  - Undefined: no cause flops; STATUS[15:8] reads 0. All other behaviour is unchanged, including ABORT transitions and mon_reset.

## Test plan
- Reset, then read offset 8 → 0x0000; mon_reset=1; cfg_locked=0.
- Write ER 0xE000/0xE0FE, OR 0x0400/0x04FF, then ARM → state 1, mon_reset=0. Drive exec=1 → state 2. Drive pc=0xE0FE → state 3. DISARM → state 0.
- ARM with ER_MIN=0xE100, ER_MAX=0xE000 → state stays 0; STATUS reads 0x0010.
- In RUN, pulse viol_in=4'b0100 for 1 cycle → mon_reset=1 in that cycle; state 4; STATUS reads 0x0404 (cause 0x4). With the macro off, STATUS reads 0x0004.
- While ARMED, write ER_MIN=0x1234 → ER_min unchanged; WERR set (STATUS 0x0009).
- MASK=0x0 during RUN with viol_in=0xF → no abort. Assert reset mid-RUN → next cycle state 0 and ER_min=0.
